// File: rtl/mapper_bus_pkg.sv
// Shared types for the mapper PRG bus master: command record, FSM states, open-bus value.
package mapper_bus_pkg;

  typedef struct packed {
    logic        write;
    logic [15:0] addr;
    logic [7:0]  data;
  } mbus_cmd_t;

  typedef enum logic [2:0] {IDLE, REQ, ARM, ACC, REL} mbus_state_t;

  localparam logic [7:0] OPEN_BUS = 8'hFF;

endpackage

// File: rtl/mbus_cmd_fifo.sv
// Command queue for the mapper bus master; honours push and pop together even when full.
module mbus_cmd_fifo
  import mapper_bus_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      push_i,
  input  mbus_cmd_t wdata_i,
  input  logic      pop_i,
  output mbus_cmd_t rdata_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int unsigned AW = $clog2(Depth);

  logic [AW:0] wptr_q, rptr_q;
  mbus_cmd_t   mem_q [Depth];
  logic        do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  // A pop in the same cycle frees the head slot, so a push into a full queue is legal.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/mapper_bus_master.sv
// Replays queued CPU-style accesses into the active mapper, one M2 period per access.
// Optional bus-grant timeout enabled by defining MAPPER_BUS_TIMEOUT_EN.
module mapper_bus_master
  import mapper_bus_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_err,
  output logic        bus_req,
  input  logic        bus_grant,
  output logic [15:0] prg_ain,
  output logic        prg_read,
  output logic        prg_write,
  output logic [7:0]  prg_din,
  input  logic [7:0]  prg_dout,
  output logic        busy
);

  mbus_cmd_t   cmd_in, head, cur_q;
  mbus_state_t state_q;
  logic        full, empty, push, pop;
  logic        bus_req_q, prg_read_q, prg_write_q, rsp_valid_q;
  logic [15:0] prg_ain_q;
  logic [7:0]  prg_din_q, rsp_data_q;

  assign cmd_in    = '{write: cmd_write, addr: cmd_addr, data: cmd_data};
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign pop       = (state_q == IDLE) && !empty;

  mbus_cmd_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .push_i  (push),
    .wdata_i (cmd_in),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

`ifdef MAPPER_BUS_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt_q;
  logic          rsp_err_q;
  assign rsp_err = rsp_err_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT, OPEN_BUS};
  assign rsp_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      bus_req_q   <= 1'b0;
      prg_read_q  <= 1'b0;
      prg_write_q <= 1'b0;
      prg_ain_q   <= '0;
      prg_din_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
`ifdef MAPPER_BUS_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
`ifdef MAPPER_BUS_TIMEOUT_EN
      rsp_err_q   <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (!empty) begin
            cur_q     <= head;
            bus_req_q <= 1'b1;
            state_q   <= REQ;
`ifdef MAPPER_BUS_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
          end
        end
        REQ: begin
          if (bus_grant) begin
            prg_ain_q <= cur_q.addr;
            prg_din_q <= cur_q.data;
            state_q   <= ARM;
`ifdef MAPPER_BUS_TIMEOUT_EN
          end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
            bus_req_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_data_q  <= OPEN_BUS;
            state_q     <= REL;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
`endif
          end
        end
        // Losing the grant mid-access is a protocol violation: freeze rather than retry.
        ARM: begin
          if (ce && bus_grant) begin
            prg_write_q <= cur_q.write;
            prg_read_q  <= !cur_q.write;
            state_q     <= ACC;
          end
        end
        ACC: begin
          if (ce && bus_grant) begin
            prg_write_q <= 1'b0;
            prg_read_q  <= 1'b0;
            bus_req_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= cur_q.write ? cur_q.data : prg_dout;
            state_q     <= REL;
          end
        end
        REL: begin
          if (!bus_grant) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_req   = bus_req_q;
  assign prg_read  = prg_read_q;
  assign prg_write = prg_write_q;
  assign prg_ain   = prg_ain_q;
  assign prg_din   = prg_din_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = !empty || (state_q != IDLE);

endmodule

// File: tb/tb_mapper_bus_master.sv
// Self-checking bench for mapper_bus_master: vector table, queue/reset/timeout sequences and
// a randomized command stream compared against an ordered command-list model.
module tb_mapper_bus_master;
  import mapper_bus_pkg::*;

  localparam int unsigned Depth = 4;
  localparam int unsigned Tmo   = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [7:0]  cmd_data = '0;
  logic        bus_grant = 1'b0;
  logic        cmd_ready, rsp_valid, rsp_err, bus_req, prg_read, prg_write, busy;
  logic [7:0]  rsp_data, prg_din, prg_dout;
  logic [15:0] prg_ain;

  int grant_mode = 0;  // 0: grant held low, 1: arbiter grants whenever bus_req is high
  int n_pass = 0;
  int n_checks = 0;
  int cyc = 0;
  int ce_phase = 0;

  logic [23:0] wr_log[$];
  logic [8:0]  rsp_log[$];
  int          rsp_cyc_log[$];
  int          wr_cyc = 0, n_wr_ce = 0, n_rd_ce = 0, rd_hi_cycles = 0, req_hi_cycles = 0;
  int          strobe_hi = 0, strobe_no_req = 0, req_rises = 0;
  logic        req_prev = 1'b0;

  mapper_bus_master #(
    .FIFO_DEPTH (Depth),
    .TIMEOUT    (Tmo)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ce        (ce),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .bus_req   (bus_req),
    .bus_grant (bus_grant),
    .prg_ain   (prg_ain),
    .prg_read  (prg_read),
    .prg_write (prg_write),
    .prg_din   (prg_din),
    .prg_dout  (prg_dout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Mapper read data model: a fixed function of the address.
  function automatic logic [7:0] rd_fn(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hFC;
  endfunction
  assign prg_dout = rd_fn(prg_ain);

  // ce every third clock; arbiter answers a cycle after the request changes.
  always @(posedge clk) begin
    cyc++;
    #1;
    ce_phase  = (ce_phase == 2) ? 0 : ce_phase + 1;
    ce        = (ce_phase == 0);
    bus_grant = (grant_mode == 1) ? bus_req : 1'b0;
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (ce && prg_write) begin
        wr_log.push_back({prg_ain, prg_din});
        wr_cyc = cyc;
        n_wr_ce++;
      end
      if (ce && prg_read) n_rd_ce++;
      if (prg_read) rd_hi_cycles++;
      if (prg_read || prg_write) strobe_hi++;
      if (bus_req) req_hi_cycles++;
      if (bus_req && !req_prev) req_rises++;
      if ((prg_read || prg_write) && !bus_req) strobe_no_req++;
      if (rsp_valid) begin
        rsp_log.push_back({rsp_err, rsp_data});
        rsp_cyc_log.push_back(cyc);
      end
    end
    req_prev = bus_req;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the accepting clock edge.
  task automatic send(input logic w, input logic [15:0] a, input logic [7:0] d,
                      output int acc_cyc);
    int t = 0;
    acc_cyc = 0;
    while (!cmd_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) begin
      check("send_ready_timeout", cmd_ready, 1);
    end else begin
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_data  = d;
      @(negedge clk);
      acc_cyc   = cyc;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_rsp(input int n, input string name);
    int t = 0;
    while (rsp_log.size() < n && t < 600) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (rsp_log.size() < n) check(name, rsp_log.size(), n);
  endtask

  typedef struct {
    logic        write;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [7:0]  exp_rsp;
  } vec_t;

  typedef struct {
    logic        write;
    logic [15:0] addr;
    logic [7:0]  data;
  } ref_cmd_t;

  vec_t     vecs[6];
  ref_cmd_t model_q[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int acc;
    int base;
    logic [8:0] r;

    vecs[0] = '{1'b1, 16'h8000, 8'h05, 8'h05};
    vecs[1] = '{1'b0, 16'h5801, 8'h00, 8'hA5};
    vecs[2] = '{1'b1, 16'hFFFF, 8'h00, 8'h00};
    vecs[3] = '{1'b0, 16'h5000, 8'h33, 8'hAC};
    vecs[4] = '{1'b1, 16'hC123, 8'h5A, 8'h5A};
    vecs[5] = '{1'b0, 16'hFFFF, 8'h00, 8'hFC};

    // Reset state
    idle(3);
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_ctrl", {rsp_valid, rsp_err, bus_req, prg_read, prg_write, busy}, 0);
    check("reset_data", {prg_ain, prg_din, rsp_data}, 0);
    reset_n = 1'b1;
    idle(2);

    // Single accesses from the vector table
    grant_mode = 1;
    for (int i = 0; i < 6; i++) begin
      vec_t v;
      v = vecs[i];
      base = rsp_log.size();
      n_wr_ce = 0;
      n_rd_ce = 0;
      rd_hi_cycles = 0;
      wr_log.delete();
      send(v.write, v.addr, v.data, acc);
      wait_rsp(base + 1, $sformatf("tbl%0d_rsp_timeout", i));
      idle(4);
      if (rsp_log.size() > base) begin
        r = rsp_log[base];
        check($sformatf("tbl%0d_rsp_data", i), r[7:0], v.exp_rsp);
        check($sformatf("tbl%0d_rsp_err", i), r[8], 0);
        check($sformatf("tbl%0d_latency_le8", i), (rsp_cyc_log[base] - acc) <= 8, 1);
        check($sformatf("tbl%0d_single_rsp", i), rsp_log.size(), base + 1);
        if (v.write) begin
          check($sformatf("tbl%0d_wr_strobes", i), n_wr_ce, 1);
          check($sformatf("tbl%0d_rd_strobes", i), n_rd_ce, 0);
          check($sformatf("tbl%0d_wr_entry", i),
                (wr_log.size() == 1) ? wr_log[0] : 24'hxxxxxx, {v.addr, v.data});
          check($sformatf("tbl%0d_rsp_after_wr", i), rsp_cyc_log[base] - wr_cyc, 1);
        end else begin
          check($sformatf("tbl%0d_rd_strobes", i), n_rd_ce, 1);
          check($sformatf("tbl%0d_no_wr", i), n_wr_ce, 0);
          check($sformatf("tbl%0d_rd_width", i), rd_hi_cycles, 3);
        end
      end
    end

`ifndef MAPPER_BUS_TIMEOUT_EN
    // Queue fill with grant held low, then drain in order with one request per command
    grant_mode = 0;
    idle(2);
    wr_log.delete();
    req_rises = 0;
    base = rsp_log.size();
    for (int i = 0; i < 5; i++) send(1'b1, 16'hC000 + 16'(i), 8'h10 + 8'(i), acc);
    check("full_cmd_ready", cmd_ready, 0);
    check("full_busy_req", {busy, bus_req}, 2'b11);
    check("full_no_rsp", rsp_log.size(), base);
    grant_mode = 1;
    send(1'b1, 16'hC005, 8'h15, acc);
    wait_rsp(base + 6, "queue_rsp_timeout");
    idle(6);
    check("queue_wr_count", wr_log.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("queue_order%0d", i), (wr_log.size() > i) ? wr_log[i] : 24'hxxxxxx,
            {16'hC000 + 16'(i), 8'h10 + 8'(i)});
    end
    check("queue_req_rises", req_rises, 6);
    check("queue_idle", busy, 0);
`endif

    // Randomized command stream against the ordered-list model
    grant_mode = 1;
    model_q.delete();
    wr_log.delete();
    base = rsp_log.size();
    for (int i = 0; i < 30; i++) begin
      ref_cmd_t c;
      c.write = 1'($urandom_range(0, 1));
      c.addr  = 16'(32'h5000 + $urandom_range(0, 32'hAFFF));
      c.data  = 8'($urandom);
      model_q.push_back(c);
      send(c.write, c.addr, c.data, acc);
      idle($urandom_range(0, 3));
    end
    wait_rsp(base + 30, "rand_rsp_timeout");
    idle(6);
    begin
      int wi = 0;
      for (int i = 0; i < 30; i++) begin
        ref_cmd_t c;
        c = model_q[i];
        r = (rsp_log.size() > base + i) ? rsp_log[base + i] : 9'h1xx;
        check($sformatf("rand%0d_rsp", i), r, {1'b0, c.write ? c.data : rd_fn(c.addr)});
        if (c.write) begin
          check($sformatf("rand%0d_wr", i), (wr_log.size() > wi) ? wr_log[wi] : 24'hxxxxxx,
                {c.addr, c.data});
          wi++;
        end
      end
      check("rand_wr_count", wr_log.size(), wi);
    end

    // Asynchronous reset during an access, with a second command still queued
    send(1'b1, 16'hA000, 8'h77, acc);
    send(1'b1, 16'hA001, 8'h78, acc);
    begin
      int t = 0;
      while (!prg_write && t < 50) begin
        @(negedge clk);
        t++;
      end
      check("rst_reached_acc", prg_write, 1);
    end
    base = rsp_log.size();
    n_wr_ce = 0;
    reset_n = 1'b0;
    #1;
    check("rst_drops_ctrl", {prg_write, prg_read, bus_req, busy}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    check("rst_cmd_ready", cmd_ready, 1);
    idle(20);
    check("rst_no_rsp", rsp_log.size(), base);
    check("rst_no_write", n_wr_ce, 0);
    check("rst_flushed", busy, 0);

`ifdef MAPPER_BUS_TIMEOUT_EN
    // Grant never arrives: request times out and the command is dropped
    grant_mode = 0;
    idle(3);
    req_hi_cycles = 0;
    strobe_hi = 0;
    base = rsp_log.size();
    send(1'b0, 16'h5000, 8'h00, acc);
    wait_rsp(base + 1, "tmo_rsp_timeout");
    idle(4);
    check("tmo_req_cycles", req_hi_cycles, Tmo);
    r = (rsp_log.size() > base) ? rsp_log[base] : 9'h000;
    check("tmo_rsp", r, {1'b1, OPEN_BUS});
    check("tmo_no_strobes", strobe_hi, 0);
    check("tmo_idle", {busy, bus_req}, 0);
`endif

    check("strobe_without_req", strobe_no_req, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
